// File: rtl/bv_inv_skolem_engine.sv
// bv_inv_skolem_engine: digit-serial invertibility condition and witness for (x <op> s) == t; optional SKOLEM_WITNESS_CHECK_EN adds wit_ok
module bv_inv_skolem_engine #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_s,
  input  logic [WIDTH-1:0] in_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic             out_ic,
  output logic             busy
`ifdef SKOLEM_WITNESS_CHECK_EN
  , output logic           wit_ok
`endif
);
  localparam int N  = WIDTH / DIGIT;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_cfg
    $error("bv_inv_skolem_engine: WIDTH must be a positive multiple of DIGIT");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] s_q, t_q, x_acc, x_next;
  logic             ic_acc, ic_next, last;
  logic [KW-1:0]    k;
  logic [DIGIT-1:0] s_d, t_d, x_d;
  logic             ic_d;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  // next state and handshake outputs
  always_comb begin
    state_n   = state;
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    busy      = state != IDLE;
    if (state == IDLE && in_valid) state_n = RUN;
    if (state == RUN && last)      state_n = DONE;
    if (state == DONE && out_ready) state_n = IDLE;
  end
  // current digit rule: OR uses the minimal witness, op 11 is never invertible
  always_comb begin
    last    = k == KW'(N - 1);
    s_d     = s_q[k*DIGIT +: DIGIT];
    t_d     = t_q[k*DIGIT +: DIGIT];
    x_d     = op_q == 2'd0 ? t_d & ~s_d : op_q == 2'd1 ? t_d : op_q == 2'd2 ? s_d ^ t_d : '0;
    ic_d    = op_q == 2'd0 ? ~|(s_d & ~t_d) : op_q == 2'd1 ? ~|(t_d & ~s_d) : op_q == 2'd2;
    x_next  = x_acc;
    x_next[k*DIGIT +: DIGIT] = x_d;
    ic_next = ic_acc & ic_d;
  end
`ifdef SKOLEM_WITNESS_CHECK_EN
  logic [WIDTH-1:0] w_res;
  // re-evaluate the literal with the finished witness over the full vectors
  always_comb
    w_res = op_q == 2'd0 ? x_next | s_q : op_q == 2'd1 ? x_next & s_q : x_next ^ s_q;
  // witness check flag, valid in DONE, cleared on result handshake
  always_ff @(posedge clk or posedge rst)
    if (rst)                                wit_ok <= 1'b0;
    else if (state == RUN && last)          wit_ok <= op_q != 2'd3 && w_res == t_q;
    else if (state == DONE && out_ready)    wit_ok <= 1'b0;
`endif
  // operand latch, digit accumulation; results only update on the final digit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q   <= '0;
      s_q    <= '0;
      t_q    <= '0;
      x_acc  <= '0;
      ic_acc <= 1'b0;
      k      <= '0;
      out_x  <= '0;
      out_ic <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      op_q   <= in_op;
      s_q    <= in_s;
      t_q    <= in_t;
      x_acc  <= '0;
      ic_acc <= in_op != 2'd3;
      k      <= '0;
    end else if (state == RUN) begin
      x_acc  <= x_next;
      ic_acc <= ic_next;
      k      <= last ? '0 : k + 1'b1;
      if (last) begin
        out_x  <= x_next;
        out_ic <= ic_next;
      end
    end
endmodule

// File: tb/tb_bv_inv_skolem_engine.sv
// tb_bv_inv_skolem_engine: directed vectors on DIGIT=1 and DIGIT=4 instances of the engine
module tb_bv_inv_skolem_engine;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iv[2], ir[2], ov[2], ordy[2], oic[2], bz[2], wk[2];
  logic [1:0] op[2];
  logic [7:0] s[2], t[2], ox[2];
  int         n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  bv_inv_skolem_engine #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_op(op[0]), .in_s(s[0]), .in_t(t[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_x(ox[0]), .out_ic(oic[0]), .busy(bz[0])
`ifdef SKOLEM_WITNESS_CHECK_EN
    , .wit_ok(wk[0])
`endif
  );
  bv_inv_skolem_engine #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_op(op[1]), .in_s(s[1]), .in_t(t[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_x(ox[1]), .out_ic(oic[1]), .busy(bz[1])
`ifdef SKOLEM_WITNESS_CHECK_EN
    , .wit_ok(wk[1])
`endif
  );
  typedef struct {logic [1:0] op; logic [7:0] s, t, x; logic ic;} vec_t;
  vec_t vecs[10];
  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d): actual=%0h required=%0h", name, d, act, exp);
    end
  endtask
  task automatic start(input int d, input logic [1:0] o, input logic [7:0] sv, input logic [7:0] tv);
    @(negedge clk);
    op[d] = o; s[d] = sv; t[d] = tv; iv[d] = 1'b1;
    chk("in_ready_idle", d, 32'(ir[d]), 1);
    @(posedge clk);
    #1 iv[d] = 1'b0;
  endtask
  task automatic wait_valid(input int d, output int lat);
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(posedge clk);
      #1;
      if (c > 0 && ov[d]) begin
        lat = c;
        break;
      end
    end
  endtask
  task automatic finish_hs(input int d);
    @(negedge clk);
    ordy[d] = 1'b1;
    @(posedge clk);
    #1 ordy[d] = 1'b0;
    chk("out_valid_after_hs", d, 32'(ov[d]), 0);
    chk("in_ready_after_hs", d, 32'(ir[d]), 1);
  endtask
  initial begin
    int lat;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 0; ordy[d] = 0; op[d] = 0; s[d] = 0; t[d] = 0;
    end
    vecs[0] = '{2'd0, 8'h0F, 8'h3F, 8'h30, 1'b1};
    vecs[1] = '{2'd0, 8'h0F, 8'h30, 8'h30, 1'b0};
    vecs[2] = '{2'd1, 8'hF0, 8'h30, 8'h30, 1'b1};
    vecs[3] = '{2'd1, 8'hF0, 8'h31, 8'h31, 1'b0};
    vecs[4] = '{2'd2, 8'hAA, 8'hFF, 8'h55, 1'b1};
    vecs[5] = '{2'd3, 8'hAA, 8'hFF, 8'h00, 1'b0};
    vecs[6] = '{2'd0, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[7] = '{2'd1, 8'hFF, 8'hFF, 8'hFF, 1'b1};
    vecs[8] = '{2'd0, 8'hFF, 8'hFF, 8'h00, 1'b1};
    vecs[9] = '{2'd2, 8'hFF, 8'h00, 8'hFF, 1'b1};
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("reset_in_ready", d, 32'(ir[d]), 1);
      chk("reset_out_valid", d, 32'(ov[d]), 0);
      chk("reset_busy", d, 32'(bz[d]), 0);
      chk("reset_out_x", d, 32'(ox[d]), 0);
      chk("reset_out_ic", d, 32'(oic[d]), 0);
`ifdef SKOLEM_WITNESS_CHECK_EN
      chk("reset_wit_ok", d, 32'(wk[d]), 0);
`endif
    end
    @(negedge clk) rst = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 10; i++) begin
        start(d, vecs[i].op, vecs[i].s, vecs[i].t);
        chk("busy_run", d, 32'(bz[d]), 1);
        wait_valid(d, lat);
        chk("latency", d, 32'(lat), d == 0 ? 8 : 2);
        chk("out_x", d, 32'(ox[d]), 32'(vecs[i].x));
        chk("out_ic", d, 32'(oic[d]), 32'(vecs[i].ic));
`ifdef SKOLEM_WITNESS_CHECK_EN
        chk("wit_ok", d, 32'(wk[d]), 32'(vecs[i].ic));
`endif
        finish_hs(d);
        chk("out_x_held", d, 32'(ox[d]), 32'(vecs[i].x));
`ifdef SKOLEM_WITNESS_CHECK_EN
        chk("wit_ok_clear", d, 32'(wk[d]), 0);
`endif
      end
    for (int d = 0; d < 2; d++) begin
      start(d, 2'd0, 8'h0F, 8'h3F);
      wait_valid(d, lat);
      chk("bp_latency", d, 32'(lat), d == 0 ? 8 : 2);
      iv[d] = 1'b1; op[d] = 2'd2; s[d] = 8'hFF; t[d] = 8'h00;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk);
        #1;
        chk("bp_out_valid", d, 32'(ov[d]), 1);
        chk("bp_out_x", d, 32'(ox[d]), 32'h30);
        chk("bp_out_ic", d, 32'(oic[d]), 1);
        chk("bp_in_ready", d, 32'(ir[d]), 0);
      end
      ordy[d] = 1'b1;
      @(posedge clk);
      #1 ordy[d] = 1'b0; iv[d] = 1'b0;
      chk("bp_in_ready_after", d, 32'(ir[d]), 1);
      chk("bp_out_valid_after", d, 32'(ov[d]), 0);
    end
    start(0, 2'd1, 8'hF0, 8'h30);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("midrun_rst_out_valid", d, 32'(ov[d]), 0);
      chk("midrun_rst_in_ready", d, 32'(ir[d]), 1);
      chk("midrun_rst_busy", d, 32'(bz[d]), 0);
      chk("midrun_rst_out_x", d, 32'(ox[d]), 0);
      chk("midrun_rst_out_ic", d, 32'(oic[d]), 0);
    end
    @(negedge clk) rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start(d, 2'd0, 8'h0F, 8'h3F);
      wait_valid(d, lat);
      chk("post_rst_latency", d, 32'(lat), d == 0 ? 8 : 2);
      chk("post_rst_out_x", d, 32'(ox[d]), 32'h30);
      chk("post_rst_out_ic", d, 32'(oic[d]), 1);
      finish_hs(d);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
